// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file writeback arbiter: entry layout,
// grant encoding and default widths.
package regfile_arb_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;
    localparam int NUM_REGS       = 32;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer for one requester; also exposes which slots hold
// live entries and their destination registers so the top can build busy_mask.
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 push,
    input  wb_entry_t                            push_entry,
    input  logic                                 pop,
    output logic                                 full,
    output logic                                 empty,
    output wb_entry_t                            head,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][DEFAULT_ADDR_W-1:0] entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Slot i is live when its distance from the read pointer (mod DEPTH) is below count.
    always_comb begin
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
            entry_rd[i]    = mem[i].rd;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file's single write port between the
// ALU pipe (A) and the load/multi-cycle unit (B), with a busy_mask for decode.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_rd,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_rd,
    input  logic [DATA_W-1:0]   b_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_rd,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    // Valid/ready: a transfer happens at posedge when valid && ready. Ready
    // depends only on buffer occupancy and flush, never on valid, so a full
    // buffer stays not-ready even in the cycle it pops.

    wb_entry_t                   a_entry, b_entry;
    wb_entry_t                   a_head, b_head;
    logic                        a_full, b_full, a_empty, b_empty;
    logic                        a_push, b_push, grant_a, grant_b;
    logic [DEPTH-1:0]            a_live, b_live;
    logic [DEPTH-1:0][ADDR_W-1:0] a_live_rd, b_live_rd;

    grant_t                      last_grant, last_grant_next;
    logic                        wr_en_next;
    logic [ADDR_W-1:0]           wr_rd_next;
    logic [DATA_W-1:0]           wr_data_next;

    assign a_ready = !a_full && !flush;
    assign b_ready = !b_full && !flush;

    // Writes to r0 complete the handshake but are dropped before buffering.
    assign a_push = a_valid && a_ready && (a_rd != '0);
    assign b_push = b_valid && b_ready && (b_rd != '0);

    assign a_entry = '{rd: a_rd, data: a_data};
    assign b_entry = '{rd: b_rd, data: b_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (a_push),
        .push_entry  (a_entry),
        .pop         (grant_a),
        .full        (a_full),
        .empty       (a_empty),
        .head        (a_head),
        .entry_valid (a_live),
        .entry_rd    (a_live_rd)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (b_push),
        .push_entry  (b_entry),
        .pop         (grant_b),
        .full        (b_full),
        .empty       (b_empty),
        .head        (b_head),
        .entry_valid (b_live),
        .entry_rd    (b_live_rd)
    );

    // Arbitration uses buffer state from before this edge's pushes, so there
    // is never a same-cycle bypass from the inputs to the write port.
    always_comb begin
        grant_a         = 1'b0;
        grant_b         = 1'b0;
        last_grant_next = last_grant;
        wr_en_next      = 1'b0;
        wr_rd_next      = wr_rd;
        wr_data_next    = wr_data;
        if (!flush) begin
            if (!a_empty && (b_empty || last_grant == GRANT_B)) begin
                grant_a = 1'b1;
            end else if (!b_empty) begin
                grant_b = 1'b1;
            end
            if (!a_empty && !b_empty) begin
                last_grant_next = grant_a ? GRANT_A : GRANT_B;
            end
            if (grant_a) begin
                wr_en_next   = 1'b1;
                wr_rd_next   = a_head.rd;
                wr_data_next = a_head.data;
            end else if (grant_b) begin
                wr_en_next   = 1'b1;
                wr_rd_next   = b_head.rd;
                wr_data_next = b_head.data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_B;
            wr_en      <= 1'b0;
            wr_rd      <= '0;
            wr_data    <= '0;
        end else begin
            last_grant <= last_grant_next;
            wr_en      <= wr_en_next;
            wr_rd      <= wr_rd_next;
            wr_data    <= wr_data_next;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_live[i]) begin
                busy_mask[a_live_rd[i]] = 1'b1;
            end
            if (b_live[i]) begin
                busy_mask[b_live_rd[i]] = 1'b1;
            end
        end
        if (wr_en) begin
            busy_mask[wr_rd] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based
// reference model of the two writeback buffers and the shared write port.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [31:0] busy_mask;

    int total = 0;
    int bad   = 0;

    // Reference model: each buffer is a queue of {rd, data}; exp_q holds the
    // write the model says the port carries after the next edge.
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    logic [36:0] exp_q[$];
    logic [4:0]  port_log[$];
    bit          m_wr_en;
    logic [4:0]  m_wr_rd;
    bit          m_last_b;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .busy_mask (busy_mask)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i][36:32]] = 1'b1;
        foreach (qb[i]) m[qb[i][36:32]] = 1'b1;
        if (m_wr_en) m[m_wr_rd] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        exp_q.delete();
        m_wr_en  = 1'b0;
        m_wr_rd  = '0;
        m_last_b = 1'b1;
    endtask

    // One clock: drive inputs after negedge, predict, then check after posedge.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic fl, output logic a_acc, output logic b_acc);
        bit ra, rb, ga, gb;
        logic [36:0] e;
        @(negedge clock);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        flush = fl;
        #1;
        ra = (qa.size() < DEPTH) && !fl;
        rb = (qb.size() < DEPTH) && !fl;
        check("a_ready", 64'(a_ready), 64'(ra));
        check("b_ready", 64'(b_ready), 64'(rb));
        a_acc = av && a_ready;
        b_acc = bv && b_ready;
        if (fl) begin
            qa.delete();
            qb.delete();
            m_wr_en = 1'b0;
        end else begin
            ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
            gb = (qb.size() > 0) && !ga;
            if (qa.size() > 0 && qb.size() > 0) m_last_b = gb;
            m_wr_en = ga || gb;
            if (ga) e = qa.pop_front();
            else if (gb) e = qb.pop_front();
            if (m_wr_en) begin
                m_wr_rd = e[36:32];
                exp_q.push_back(e);
            end
            if (av && ra && ard != 0) qa.push_back({ard, ad});
            if (bv && rb && brd != 0) qb.push_back({brd, bd});
        end
        @(posedge clock);
        #1;
        check("wr_en", 64'(wr_en), 64'(m_wr_en));
        if (wr_en) begin
            port_log.push_back(wr_rd);
            if (exp_q.size() == 0) begin
                check("wr_port_extra", 64'(wr_en), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("wr_port", 64'({wr_rd, wr_data}), 64'(e));
            end
        end
        check("busy_mask", 64'(busy_mask), 64'(model_busy()));
    endtask

    task automatic idle(input int n);
        logic x, y;
        repeat (n) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, x, y);
    endtask

    task automatic random_cycles(input int n, input bit allow_flush);
        logic x, y;
        repeat (n) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  allow_flush && ($urandom_range(0, 19) == 0), x, y);
        end
    endtask

    initial begin
        logic        aa, ba;
        int          ai, bi;
        logic [4:0]  rr_seq [8];

        reset = 1'b0;
        flush = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check("reset_wr_en", 64'(wr_en), 64'(0));
        check("reset_wr_rd", 64'(wr_rd), 64'(0));
        check("reset_wr_data", 64'(wr_data), 64'(0));
        check("reset_busy", 64'(busy_mask), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        idle(10);

        // Single A write: visible on the port one edge after acceptance.
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, aa, ba);
        check("single_accept", 64'(aa), 64'(1));
        check("single_busy3", 64'(busy_mask[3]), 64'(1));
        idle(1);
        check("single_wr_en", 64'(wr_en), 64'(1));
        check("single_wr_rd", 64'(wr_rd), 64'(3));
        check("single_wr_data", 64'(wr_data), 64'(32'hDEADBEEF));
        idle(1);
        check("single_busy_clear", 64'(busy_mask), 64'(0));

        // Continuous contention: values advance only on accepted handshakes.
        rr_seq = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};
        port_log.delete();
        ai = 0;
        bi = 0;
        for (int c = 0; c < 40 && (ai < 4 || bi < 4); c++) begin
            cycle(1'(ai < 4), 5'(ai + 1), 32'hA000 + 32'(ai),
                  1'(bi < 4), 5'(bi + 5), 32'hB000 + 32'(bi), 1'b0, aa, ba);
            if (aa) ai++;
            if (ba) bi++;
        end
        check("contention_a_accepts", 64'(ai), 64'(4));
        check("contention_b_accepts", 64'(bi), 64'(4));
        idle(6);
        check("rr_count", 64'(port_log.size()), 64'(8));
        for (int k = 0; k < 8 && k < port_log.size(); k++) begin
            check("rr_order", 64'(port_log[k]), 64'(rr_seq[k]));
        end

        // r0 writes handshake but never reach the port or busy_mask.
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, aa, ba);
        check("rd0_handshake", 64'(aa), 64'(1));
        check("rd0_busy", 64'(busy_mask), 64'(0));
        idle(1);
        check("rd0_no_write", 64'(wr_en), 64'(0));

        // Fill both buffers, then flush while inputs remain valid.
        cycle(1'b1, 5'd10, 32'h10, 1'b1, 5'd20, 32'h20, 1'b0, aa, ba);
        cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd21, 32'h21, 1'b0, aa, ba);
        cycle(1'b1, 5'd12, 32'h12, 1'b1, 5'd22, 32'h22, 1'b1, aa, ba);
        check("flush_no_accept", 64'({aa, ba}), 64'(0));
        check("flush_wr_en", 64'(wr_en), 64'(0));
        check("flush_busy", 64'(busy_mask), 64'(0));
        idle(4);

        random_cycles(300, 1'b1);

        // Asynchronous reset in the middle of traffic clears outputs at once.
        random_cycles(20, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_wr_en", 64'(wr_en), 64'(0));
        check("async_wr_rd", 64'(wr_rd), 64'(0));
        check("async_wr_data", 64'(wr_data), 64'(0));
        check("async_busy", 64'(busy_mask), 64'(0));
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        random_cycles(100, 1'b1);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
